// File: rtl/pc_ctrl.sv
// pc_ctrl: program counter sequencer with halt, absolute branch/call via a target
// table, and a small return-address stack with a sticky error flag.
module pc_ctrl #(
   parameter int D  = 9,
   parameter int SD = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic       stall_i,
   input  logic       halt_i,
   input  logic       branch_i,
   input  logic       cond_i,
   input  logic       call_i,
   input  logic       ret_i,
   input  logic [4:0] lut_idx_i,
   output logic [4:0] lut_addr_o,
   input  logic [D:0] lut_target_i,
   output logic [D:0] pc_o,
   output logic       running_o,
   output logic       done_o,
   output logic       err_o,
   output logic [2:0] depth_o
);
   localparam int AW = (SD > 1) ? $clog2(SD) : 1;
   localparam logic [2:0] SD_L = 3'(SD);
   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
   state_t     state_q, state_d;
   logic [D:0] pc_q, pc_d, pc_inc;
   logic [2:0] depth_q, depth_d, top;
   logic       err_q, err_d, push;
   logic [D:0] stk_q [SD];
   assign pc_inc     = pc_q + (D+1)'(1);
   assign top        = depth_q - 3'd1;
   assign lut_addr_o = lut_idx_i;
   assign pc_o       = pc_q;
   assign running_o  = state_q == RUN;
   assign done_o     = state_q == HALTED;
   assign err_o      = err_q;
   assign depth_o    = depth_q;
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      depth_d = depth_q;
      err_d   = err_q;
      push    = 1'b0;
      // stall only freezes a running machine; start always wins otherwise
      if (start_i && (state_q != RUN || !stall_i)) begin
         state_d = RUN;
         pc_d    = '0;
         depth_d = '0;
         err_d   = 1'b0;
      end else if (state_q == RUN && !stall_i) begin
         if (halt_i) begin
            state_d = HALTED;
         end else if (ret_i && call_i) begin
            err_d = 1'b1;
            pc_d  = pc_inc;
         end else if (ret_i) begin
            err_d   = err_q | (depth_q == '0);
            pc_d    = (depth_q != '0) ? stk_q[top[AW-1:0]] : pc_inc;
            depth_d = (depth_q != '0) ? top : depth_q;
         end else if (call_i) begin
            push    = depth_q < SD_L;
            err_d   = err_q | !push;
            pc_d    = push ? lut_target_i : pc_inc;
            depth_d = push ? depth_q + 3'd1 : depth_q;
         end else begin
            pc_d = (branch_i && cond_i) ? lut_target_i : pc_inc;
         end
      end
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         pc_q    <= '0;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end
   always_ff @(posedge clk_i) begin
      if (push) stk_q[depth_q[AW-1:0]] <= pc_inc;
   end
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed scenarios plus randomized traffic against a queue-based
// reference model of the sequencer.
module tb_pc_ctrl;
   logic       clk_i = 1'b0, reset_i = 1'b1;
   logic       start_i = 1'b0, stall_i = 1'b0, halt_i = 1'b0, branch_i = 1'b0;
   logic       cond_i = 1'b0, call_i = 1'b0, ret_i = 1'b0;
   logic [4:0] lut_idx_i = '0, lut_addr_o;
   logic [9:0] lut_target_i = '0, pc_o;
   logic       running_o, done_o, err_o;
   logic [2:0] depth_o;
   int n_chk = 0, n_pass = 0;
   int m_state, m_pc;
   bit m_err;
   int m_stk[$];

   pc_ctrl dut (
      .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .stall_i(stall_i),
      .halt_i(halt_i), .branch_i(branch_i), .cond_i(cond_i), .call_i(call_i),
      .ret_i(ret_i), .lut_idx_i(lut_idx_i), .lut_addr_o(lut_addr_o),
      .lut_target_i(lut_target_i), .pc_o(pc_o), .running_o(running_o),
      .done_o(done_o), .err_o(err_o), .depth_o(depth_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic drive(bit st, bit sl, bit h, bit b, bit c, bit ca, bit r, int idx, int tgt);
      start_i = st; stall_i = sl; halt_i = h; branch_i = b; cond_i = c;
      call_i = ca; ret_i = r; lut_idx_i = 5'(idx); lut_target_i = 10'(tgt);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic model_reset();
      m_state = 0; m_pc = 0; m_err = 0; m_stk.delete();
   endtask

   // 0 = idle, 1 = run, 2 = halted; stack is a queue whose back is the top
   task automatic model_step();
      int inc = (m_pc + 1) % 1024;
      if (start_i && (m_state != 1 || !stall_i)) begin
         m_state = 1; m_pc = 0; m_err = 0; m_stk.delete();
      end else if (m_state == 1 && !stall_i) begin
         if (halt_i) m_state = 2;
         else if (ret_i && call_i) begin m_err = 1; m_pc = inc; end
         else if (ret_i) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_err = 1; m_pc = inc; end
         end else if (call_i) begin
            if (m_stk.size() < 4) begin m_stk.push_back(inc); m_pc = int'(lut_target_i); end
            else begin m_err = 1; m_pc = inc; end
         end else if (branch_i && cond_i) m_pc = int'(lut_target_i);
         else m_pc = inc;
      end
   endtask

   task automatic check_model(string tag);
      chk({tag, "_pc"}, 32'(pc_o), 32'(m_pc));
      chk({tag, "_running"}, 32'(running_o), 32'(m_state == 1));
      chk({tag, "_done"}, 32'(done_o), 32'(m_state == 2));
      chk({tag, "_err"}, 32'(err_o), 32'(m_err));
      chk({tag, "_depth"}, 32'(depth_o), 32'(m_stk.size()));
   endtask

   task automatic step(string tag);
      chk({tag, "_lut_addr"}, 32'(lut_addr_o), 32'(lut_idx_i));
      model_step();
      @(posedge clk_i); #1;
      check_model(tag);
   endtask

   task automatic pulse_reset();
      #2 reset_i = 1'b1;
      #1 model_reset();
      chk("async_rst_pc", 32'(pc_o), 0);
      chk("async_rst_done", 32'(done_o), 0);
      chk("async_rst_running", 32'(running_o), 0);
      chk("async_rst_err", 32'(err_o), 0);
      chk("async_rst_depth", 32'(depth_o), 0);
      #1 reset_i = 1'b0;
   endtask

   initial begin
      idle();
      repeat (2) @(posedge clk_i);
      #1;
      model_reset();
      check_model("reset");
      reset_i = 1'b0;
      step("idle_hold");
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("start");
      chk("start_pc", 32'(pc_o), 0);
      chk("start_running", 32'(running_o), 1);
      idle();
      for (int i = 1; i <= 6; i++) begin
         step("count");
         chk("count_pc", 32'(pc_o), 32'(i));
      end
      drive(0, 0, 0, 1, 1, 0, 0, 3, 23);
      chk("br_lut_addr", 32'(lut_addr_o), 3);
      step("br_taken");
      chk("br_taken_pc", 32'(pc_o), 23);
      drive(0, 0, 0, 1, 1, 0, 0, 7, 6);
      step("br_back");
      drive(0, 0, 0, 1, 0, 0, 0, 3, 23);
      step("br_not_taken");
      chk("br_not_taken_pc", 32'(pc_o), 7);
      drive(0, 0, 0, 1, 1, 0, 0, 1, 10);
      step("br_to10");
      drive(0, 0, 0, 0, 0, 1, 0, 4, 145);
      step("call");
      chk("call_pc", 32'(pc_o), 145);
      chk("call_depth", 32'(depth_o), 1);
      idle();
      step("after_call");
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      step("ret");
      chk("ret_pc", 32'(pc_o), 11);
      chk("ret_depth", 32'(depth_o), 0);
      step("ret_underflow");
      chk("ret_underflow_err", 32'(err_o), 1);
      chk("ret_underflow_pc", 32'(pc_o), 12);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("restart");
      chk("restart_err", 32'(err_o), 0);
      for (int k = 1; k <= 5; k++) begin
         drive(0, 0, 0, 0, 0, 1, 0, k, 100 * k);
         step("call_chain");
      end
      chk("overflow_depth", 32'(depth_o), 4);
      chk("overflow_err", 32'(err_o), 1);
      chk("overflow_pc", 32'(pc_o), 401);
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      step("ret_after_ovf");
      chk("ret_after_ovf_pc", 32'(pc_o), 301);
      drive(0, 0, 0, 0, 0, 1, 1, 2, 77);
      step("call_ret_conflict");
      chk("conflict_pc", 32'(pc_o), 302);
      chk("conflict_depth", 32'(depth_o), 3);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("restart2");
      drive(0, 0, 0, 1, 1, 0, 0, 9, 1023);
      step("br_1023");
      chk("br_1023_pc", 32'(pc_o), 1023);
      idle();
      step("wrap");
      chk("wrap_pc", 32'(pc_o), 0);
      chk("wrap_err", 32'(err_o), 0);
      drive(1, 1, 1, 1, 1, 1, 0, 2, 500);
      for (int i = 0; i < 3; i++) begin
         step("stall");
         chk("stall_pc", 32'(pc_o), 0);
      end
      drive(0, 0, 0, 1, 1, 0, 0, 5, 40);
      step("br_40");
      drive(0, 0, 1, 1, 1, 1, 1, 5, 99);
      step("halt");
      chk("halt_done", 32'(done_o), 1);
      chk("halt_pc", 32'(pc_o), 40);
      drive(0, 1, 0, 1, 1, 1, 1, 6, 300);
      repeat (2) step("halted_hold");
      chk("halted_hold_pc", 32'(pc_o), 40);
      pulse_reset();
      idle();
      step("post_reset_idle");
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(99) < 5, $urandom_range(99) < 15, $urandom_range(99) < 3,
               $urandom_range(99) < 30, $urandom_range(99) < 50, $urandom_range(99) < 15,
               $urandom_range(99) < 15, int'($urandom_range(31)), int'($urandom_range(1023)));
         if ($urandom_range(199) == 0) pulse_reset();
         else step("rnd");
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
